result_drain_collector: RTL and testbench
=========================================

Name: result_drain_collector

Overview:
- Sits at the tail of the PE result shift chain and acts as its receiving end.
- Drives the chain's ResultCapture select: one load cycle latches every PE's local result, then shift cycles move the results toward the tail.
- Captures the CHAIN_DEPTH result words arriving at the tail, buffers them in a FIFO, and presents them downstream on a valid/ready stream with a last marker.

Parameters:
- DATA_WIDTH, 8: bit width of one result element.
- CHAIN_DEPTH, 4: number of chain stages, which equals the number of words per drain.
- FIFO_DEPTH, 8: output FIFO entries. Must be a power of 2 and >= CHAIN_DEPTH; checked by an elaboration-time assertion.

Ports:
- Clk  in  1  clock; the single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to drain the chain.
- ResultCapture  out  1  chain select: 0 = load local results, 1 = shift.
- ChainIn_0..ChainIn_3  in  4*DATA_WIDTH each  result lanes from the tail stage of the chain.
- out_data  out  16*DATA_WIDTH  packed word {ChainIn_3, ChainIn_2, ChainIn_1, ChainIn_0}.
- out_last  out  1  marks the final word of a drain.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accept.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last word is written into the FIFO.

Behaviour:
- Reset, sampled on the Clk edge while rst=1:
  - FSM goes to IDLE and the FIFO is flushed.
  - ResultCapture=1; out_valid=0; busy=0; done=0; out_last=0; out_data=0.
  - Reset asserted mid-drain aborts the drain; partial words are discarded.
- ResultCapture idles at 1 so the chain never reloads unintentionally. It is 0 only in LOAD.
- The chain has no stall, so space is reserved up front: a drain begins only when free entries >= CHAIN_DEPTH. Free entries = FIFO_DEPTH - count, registered.
- FSM states and transitions:
  - IDLE:
    - start=1 and free >= CHAIN_DEPTH -> LOAD.
    - start=1 and free < CHAIN_DEPTH -> WAIT_SPACE.
    - start=0 -> stay.
  - WAIT_SPACE: stay until free >= CHAIN_DEPTH, then -> LOAD. Pops continue while waiting.
  - LOAD: ResultCapture=0 for exactly one cycle; -> DRAIN.
  - DRAIN:
    - ResultCapture=1; beat counter k runs 0..CHAIN_DEPTH-1.
    - Each cycle pushes {ChainIn_3..0} into the FIFO, with last = (k == CHAIN_DEPTH-1).
    - After the k=CHAIN_DEPTH-1 push -> DONE.
  - DONE: done=1 for one cycle; -> IDLE.
- start is ignored in every state except IDLE; no queuing.
- Latency:
  - start (cycle 0) -> LOAD (cycle 1) -> first push (cycle 2) -> first out_valid (cycle 3).
  - done is high in cycle CHAIN_DEPTH+2.
  - Minimum start-to-start spacing is CHAIN_DEPTH+3 cycles.
- Word order: word 0 is the PE nearest the collector; word CHAIN_DEPTH-1 is the chain head.
- FIFO behaviour:
  - Show-ahead: out_data and out_last are valid whenever out_valid=1.
  - Pop occurs on out_valid & out_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Push while full cannot occur because of the reservation; this is covered by an assertion.
  - Pointers wrap modulo FIFO_DEPTH. count width is clog2(FIFO_DEPTH)+1.
- out_valid drops in the cycle after the last pop. No combinational path exists from out_ready to out_valid.

Optional Feature:
- Macro: RESULT_DRAIN_RELU_EN.
- Defined: each DATA_WIDTH element of the pushed word is treated as signed two's complement. Negative elements are replaced by 0 before the FIFO write; this adds no latency.
- Undefined: words pass unmodified.

Decomposition:
- Package result_drain_pkg holds:
  - the FSM state enum {IDLE, WAIT_SPACE, LOAD, DRAIN, DONE};
  - the lane-count constant LANES=4;
  - the element-clamp function used by RESULT_DRAIN_RELU_EN.
- One sub-module, result_fifo: synchronous show-ahead FIFO with parameterised width and depth, exposing count.

Test Plan (DATA_WIDTH=8, CHAIN_DEPTH=4, FIFO_DEPTH=8, chain model attached):
- Basic drain: PE locals 0x11.., 0x22.., 0x33.., 0x44.. (tail to head), start pulse, out_ready=1 -> ResultCapture=0 in cycle 1 only; words emitted in order 0x11.., 0x22.., 0x33.., 0x44..; out_last on the 4th word only; done in cycle 6.
- Backpressure: out_ready=0, two starts spaced 7 cycles apart -> second start enters WAIT_SPACE? No: count=4 leaves free=4, so it proceeds; count reaches 8 and out_valid stays 1. A third start then sits in WAIT_SPACE with ResultCapture=1 until 4 pops occur.
- Start while busy: start asserted during DRAIN -> ignored; exactly 4 words pushed; no second LOAD.
- Reset mid-drain: rst=1 at DRAIN beat k=2 -> next cycle out_valid=0, busy=0, ResultCapture=1; a subsequent start produces a clean 4-word drain.
- Simultaneous push/pop: out_ready toggling 1/0 during DRAIN -> count never exceeds 4; no word lost or duplicated; pointer wrap exercised over 5 consecutive drains.
- RESULT_DRAIN_RELU_EN defined: lane element 0x80 -> 0x00 and 0x7F -> 0x7F. With the macro undefined, 0x80 passes through unchanged.

Source files
------------

// File: rtl/result_drain_pkg.sv
// -----------------------------------------------------------------------------
// result_drain_pkg
// Shared definitions for the result drain collector:
//   - state_t   : collector FSM states
//   - LANES     : number of ChainIn lanes (and elements per lane)
//   - clamp_neg : element clamp used when RESULT_DRAIN_RELU_EN is defined
// -----------------------------------------------------------------------------
package result_drain_pkg;

  localparam int LANES = 4;

  // Widest element the clamp helper accepts; elements are zero-extended into it.
  localparam int ELEM_MAX_W = 64;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_SPACE = 3'd1,
    LOAD       = 3'd2,
    DRAIN      = 3'd3,
    DONE       = 3'd4
  } state_t;

  // Treat the low 'width' bits of elem as signed two's complement and
  // replace negative values with zero.
  function automatic logic [ELEM_MAX_W-1:0] clamp_neg(
    input logic [ELEM_MAX_W-1:0] elem,
    input int unsigned           width
  );
    return elem[width-1] ? '0 : elem;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
// Synchronous show-ahead FIFO. pop_data is the head entry whenever valid=1
// and reads as zero when empty. Pops are ignored while empty.
// Ports:
//   Clk, rst          clock, synchronous active-high reset (flushes)
//   push, push_data   write request and data
//   pop               read request (gated internally by valid)
//   pop_data          head entry (zero when empty)
//   valid             FIFO non-empty
//   count             number of stored entries, 0..DEPTH
// DEPTH must be a power of 2 >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     Clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge Clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the flushed pointers/count make
  // stale contents unreachable and the output mask below hides them.
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = valid ? mem[rd_ptr] : '0;

  // The collector reserves space before draining, so a push never meets a full FIFO.
  a_no_overflow: assert property (@(posedge Clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/result_drain_collector.sv
// -----------------------------------------------------------------------------
// result_drain_collector
// Receiving end of the PE result shift chain. On start it pulses
// ResultCapture low for one cycle (load every PE's local result), then shifts
// CHAIN_DEPTH words out of the chain tail into an output FIFO, tagging the last
// word. Words are presented on a valid/ready stream.
// Ports:
//   Clk, rst            clock, synchronous active-high reset (aborts drain, flushes FIFO)
//   start               one-cycle drain request (honoured only in IDLE)
//   ResultCapture       chain select: 0 = load local results, 1 = shift
//   ChainIn_0..3        result lanes from the chain tail stage
//   out_data, out_last  stream word {ChainIn_3..0} and last-of-drain marker
//   out_valid, out_ready stream handshake
//   busy                high whenever the FSM is not IDLE
//   done                one-cycle pulse after the last word is written
// Optional feature: define RESULT_DRAIN_RELU_EN to clamp negative
// DATA_WIDTH elements to zero before the FIFO write.
// -----------------------------------------------------------------------------
module result_drain_collector
  import result_drain_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int CHAIN_DEPTH = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                Clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                ResultCapture,
  input  logic [LANES*DATA_WIDTH-1:0]         ChainIn_0,
  input  logic [LANES*DATA_WIDTH-1:0]         ChainIn_1,
  input  logic [LANES*DATA_WIDTH-1:0]         ChainIn_2,
  input  logic [LANES*DATA_WIDTH-1:0]         ChainIn_3,
  output logic [LANES*LANES*DATA_WIDTH-1:0]   out_data,
  output logic                                out_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy,
  output logic                                done
);

  localparam int WORD_W = LANES * LANES * DATA_WIDTH;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BEAT_W = (CHAIN_DEPTH > 1) ? $clog2(CHAIN_DEPTH) : 1;

  if (FIFO_DEPTH < CHAIN_DEPTH || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_cfg_check
    $error("result_drain_collector: FIFO_DEPTH must be a power of 2 and >= CHAIN_DEPTH");
  end

  state_t              state;
  state_t              state_nxt;
  logic [BEAT_W-1:0]   beat;
  logic                last_beat;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    free;
  logic                space_ok;
  logic                push;
  logic [WORD_W-1:0]   raw_word;
  logic [WORD_W-1:0]   push_word;
  logic [WORD_W:0]     fifo_q;

  // The chain cannot stall, so a drain only starts with a full drain's worth of space.
  assign free      = CNT_W'(FIFO_DEPTH) - count;
  assign space_ok  = (free >= CNT_W'(CHAIN_DEPTH));
  assign last_beat = (beat == BEAT_W'(CHAIN_DEPTH - 1));
  assign push      = (state == DRAIN);

  // Idles at 1 so the chain never reloads unintentionally.
  assign ResultCapture = (state != LOAD);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  // NOTE: every variable driven in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (start) state_nxt = space_ok ? LOAD : WAIT_SPACE;
      WAIT_SPACE: if (space_ok) state_nxt = LOAD;
      LOAD:       state_nxt = DRAIN;
      DRAIN:      if (last_beat) state_nxt = DONE;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      if (state == DRAIN && !last_beat) beat <= beat + 1'b1;
      else                              beat <= '0;
    end
  end

  // Word 0 is the PE nearest the collector; lane 0 is the least significant.
  assign raw_word = {ChainIn_3, ChainIn_2, ChainIn_1, ChainIn_0};

`ifdef RESULT_DRAIN_RELU_EN
  always_comb begin
    logic [ELEM_MAX_W-1:0] elem;
    push_word = raw_word;
    elem      = '0;
    for (int i = 0; i < LANES * LANES; i++) begin
      elem = clamp_neg(ELEM_MAX_W'(raw_word[i*DATA_WIDTH +: DATA_WIDTH]), DATA_WIDTH);
      push_word[i*DATA_WIDTH +: DATA_WIDTH] = elem[DATA_WIDTH-1:0];
    end
  end
`else
  assign push_word = raw_word;
`endif

  result_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk       (Clk),
    .rst       (rst),
    .push      (push),
    .push_data ({last_beat, push_word}),
    .pop       (out_ready),
    .pop_data  (fifo_q),
    .valid     (out_valid),
    .count     (count)
  );

  assign out_last = fifo_q[WORD_W];
  assign out_data = fifo_q[WORD_W-1:0];

endmodule

// File: tb/tb_result_drain_collector.sv
// -----------------------------------------------------------------------------
// tb_result_drain_collector
// Drives result_drain_collector (DATA_WIDTH=8, CHAIN_DEPTH=4, FIFO_DEPTH=8)
// through an attached shift-chain model and compares every cycle against a
// timeline/queue reference model of the collector's externally visible rules.
// -----------------------------------------------------------------------------
module tb_result_drain_collector;

  localparam int DW     = 8;
  localparam int CD     = 4;
  localparam int FD     = 8;
  localparam int LANE_W = 4 * DW;
  localparam int WORD_W = 16 * DW;

  logic              Clk;
  logic              rst;
  logic              start;
  logic              ResultCapture;
  logic [LANE_W-1:0] ChainIn_0, ChainIn_1, ChainIn_2, ChainIn_3;
  logic [WORD_W-1:0] out_data;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  result_drain_collector #(
    .DATA_WIDTH  (DW),
    .CHAIN_DEPTH (CD),
    .FIFO_DEPTH  (FD)
  ) dut (
    .Clk           (Clk),
    .rst           (rst),
    .start         (start),
    .ResultCapture (ResultCapture),
    .ChainIn_0     (ChainIn_0),
    .ChainIn_1     (ChainIn_1),
    .ChainIn_2     (ChainIn_2),
    .ChainIn_3     (ChainIn_3),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .done          (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- chain model: stage 0 is the tail ----------------
  logic [WORD_W-1:0] pe_local [CD];
  logic [WORD_W-1:0] stage    [CD];
  logic [WORD_W-1:0] tail_word;

  always @(posedge Clk) begin
    if (!ResultCapture) begin
      for (int i = 0; i < CD; i++) stage[i] <= pe_local[i];
    end else begin
      for (int i = 0; i < CD - 1; i++) stage[i] <= stage[i+1];
      stage[CD-1] <= '0;
    end
  end

  assign tail_word = stage[0];
  assign ChainIn_0 = tail_word[0*LANE_W +: LANE_W];
  assign ChainIn_1 = tail_word[1*LANE_W +: LANE_W];
  assign ChainIn_2 = tail_word[2*LANE_W +: LANE_W];
  assign ChainIn_3 = tail_word[3*LANE_W +: LANE_W];

  // ---------------- reference model ----------------
  typedef struct {
    logic              last;
    logic [WORD_W-1:0] data;
  } entry_t;

  entry_t            exp_q [$];
  logic [WORD_W-1:0] snap  [CD];
  int                m_t;     // -1: no drain; 0: load cycle; 1..CD: beats; CD+1: done cycle
  bit                m_wait;  // start accepted but waiting for FIFO space
  int                n_tests;
  int                n_failed;
  int                cyc;

  function automatic logic [WORD_W-1:0] relu(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = w;
`ifdef RESULT_DRAIN_RELU_EN
    for (int i = 0; i < 16; i++)
      if (w[i*DW + DW - 1]) r[i*DW +: DW] = '0;
`endif
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_t    = -1;
    m_wait = 1'b0;
  endtask

  // Compare this cycle's outputs, then advance the model across the edge.
  task automatic cycle();
    bit space;
    @(negedge Clk);
    check("ResultCapture", WORD_W'(ResultCapture), WORD_W'(m_t != 0));
    check("busy",          WORD_W'(busy),          WORD_W'(m_wait || m_t >= 0));
    check("done",          WORD_W'(done),          WORD_W'(m_t == CD + 1));
    check("out_valid",     WORD_W'(out_valid),     WORD_W'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_data", out_data,         exp_q[0].data);
      check("out_last", WORD_W'(out_last), WORD_W'(exp_q[0].last));
    end else begin
      check("out_data_idle", out_data,         '0);
      check("out_last_idle", WORD_W'(out_last), '0);
    end

    if (rst) begin
      model_reset();
    end else begin
      space = (FD - exp_q.size()) >= CD;
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (m_t >= 1 && m_t <= CD) exp_q.push_back('{last: (m_t == CD), data: snap[m_t-1]});
      if (m_t == -1 && !m_wait) begin
        if (start) begin
          if (space) m_t = 0;
          else       m_wait = 1'b1;
        end
      end else if (m_wait) begin
        if (space) begin
          m_wait = 1'b0;
          m_t    = 0;
        end
      end else if (m_t == CD + 1) begin
        m_t = -1;
      end else begin
        if (m_t == 0)
          for (int i = 0; i < CD; i++) snap[i] = relu(pe_local[i]);
        m_t++;
      end
    end
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_tests   = 0;
    n_failed  = 0;
    cyc       = 0;
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < CD; i++) pe_local[i] = '0;
    repeat (2) @(posedge Clk);
    #1;
    model_reset();
    rst = 1'b0;

    // Reset state.
    cycle();

    // Basic drain: known pattern, ready always high.
    pe_local[0] = {16{8'h11}};
    pe_local[1] = {16{8'h22}};
    pe_local[2] = {16{8'h33}};
    pe_local[3] = {16{8'h44}};
    out_ready = 1'b1;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (9) cycle();

    // Backpressure: two drains fill the FIFO, the third waits for space.
    out_ready = 1'b0;
    for (int i = 0; i < CD; i++) pe_local[i] = rand_word();
    start = 1'b1; cycle(); start = 1'b0;
    repeat (6) cycle();
    for (int i = 0; i < CD; i++) pe_local[i] = rand_word();
    start = 1'b1; cycle(); start = 1'b0;
    repeat (6) cycle();
    for (int i = 0; i < CD; i++) pe_local[i] = rand_word();
    start = 1'b1; cycle(); start = 1'b0;
    repeat (5) cycle();
    out_ready = 1'b1;
    repeat (20) cycle();

    // Start while busy is ignored.
    for (int i = 0; i < CD; i++) pe_local[i] = rand_word();
    start = 1'b1; cycle(); start = 1'b0;
    repeat (2) cycle();
    start = 1'b1; cycle(); cycle(); start = 1'b0;
    repeat (8) cycle();

    // Reset at drain beat k=2, then a clean drain.
    out_ready = 1'b0;
    for (int i = 0; i < CD; i++) pe_local[i] = rand_word();
    start = 1'b1; cycle(); start = 1'b0;
    repeat (3) cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < CD; i++) pe_local[i] = rand_word();
    start = 1'b1; cycle(); start = 1'b0;
    repeat (9) cycle();

    // Simultaneous push/pop: ready toggles during drains, 5 back-to-back drains.
    for (int d = 0; d < 5; d++) begin
      for (int i = 0; i < CD; i++) pe_local[i] = rand_word();
      out_ready = 1'b1;
      start = 1'b1; cycle(); start = 1'b0;
      for (int c = 1; c < CD + 3; c++) begin
        out_ready = (c >= 2 && c <= CD + 1) ? c[0] : 1'b1;
        cycle();
      end
    end
    out_ready = 1'b1;
    repeat (10) cycle();

    // Sign boundary elements: 0x80 clamps only when ReLU is built in.
    pe_local[0] = {16{8'h80}};
    pe_local[1] = {16{8'h7F}};
    pe_local[2] = {8{8'h80, 8'h7F}};
    pe_local[3] = {8{8'hFF, 8'h01}};
    start = 1'b1; cycle(); start = 1'b0;
    repeat (9) cycle();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      start     = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (m_t == -1 && !m_wait)
        for (int i = 0; i < CD; i++) pe_local[i] = rand_word();
      cycle();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (20) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
